// File: rtl/onehot_to_bin_pipe_hyper.sv
// One-hot to binary encoder with a 2-entry in-order output buffer and
// multi-hot error tracking (sticky flag plus saturating counter).
// Words are encoded at acceptance; the buffer head drives the outputs
// straight from registers, so the output data is stable under backpressure.
module onehot_to_bin_pipe_hyper #(
    parameter int unsigned ONEHOT_WIDTH  = 16,
    parameter int unsigned BIN_WIDTH     = $clog2(ONEHOT_WIDTH),
    parameter bit          PRIO_LSB      = 1'b1,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [ONEHOT_WIDTH-1:0]  in_onehot_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [BIN_WIDTH-1:0]     out_bin_o,
    output logic                     out_zero_o,
    output logic                     out_multi_o,
    input  logic                     err_clr_i,
    output logic                     err_sticky_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    // Elaboration-time parameter legality checks
    if (ONEHOT_WIDTH < 2 || ONEHOT_WIDTH > 64) begin : gen_bad_width
        $error("ONEHOT_WIDTH must be in 2..64");
    end
    if (BIN_WIDTH != $clog2(ONEHOT_WIDTH)) begin : gen_bad_bin_width
        $error("BIN_WIDTH is derived from ONEHOT_WIDTH and must not be overridden");
    end
    if (ERR_CNT_WIDTH < 1 || ERR_CNT_WIDTH > 32) begin : gen_bad_cnt_width
        $error("ERR_CNT_WIDTH must be in 1..32");
    end

    // Buffer occupancy
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]               state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;

    // Head entry is the oldest word and feeds the outputs; tail only used in FULL
    logic [BIN_WIDTH-1:0]     head_bin_q, head_bin_d;
    logic                     head_zero_q, head_zero_d;
    logic                     head_multi_q, head_multi_d;
    logic [BIN_WIDTH-1:0]     tail_bin_q, tail_bin_d;
    logic                     tail_zero_q, tail_zero_d;
    logic                     tail_multi_q, tail_multi_d;

    logic                     err_sticky_q, err_sticky_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic [BIN_WIDTH-1:0]     enc_bin;
    logic                     enc_zero;
    logic                     enc_multi;
    logic                     push;
    logic                     pop;

    // Handshakes use only registered ready/valid, never out_ready_i -> in_ready_o
    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_q & out_ready_i;

    // Encode the incoming word: lowest-set-bit index or OR of all set indices
    always_comb begin
        enc_bin = '0;
        if (PRIO_LSB) begin
            // Descending scan so the lowest set bit is the last to write
            for (int i = int'(ONEHOT_WIDTH) - 1; i >= 0; i--) begin
                if (in_onehot_i[i]) begin
                    enc_bin = BIN_WIDTH'(i);
                end
            end
        end else begin
            for (int i = 0; i < int'(ONEHOT_WIDTH); i++) begin
                if (in_onehot_i[i]) begin
                    enc_bin = enc_bin | BIN_WIDTH'(i);
                end
            end
        end
    end

    // Zero / multi-hot flags; x & (x-1) is nonzero iff two or more bits are set
    always_comb begin
        enc_zero  = (in_onehot_i == '0);
        enc_multi = ((in_onehot_i & (in_onehot_i - ONEHOT_WIDTH'(1))) != '0);
    end

    // Buffer next-state: occupancy transitions and entry movement
    always_comb begin
        state_d      = state_q;
        head_bin_d   = head_bin_q;
        head_zero_d  = head_zero_q;
        head_multi_d = head_multi_q;
        tail_bin_d   = tail_bin_q;
        tail_zero_d  = tail_zero_q;
        tail_multi_d = tail_multi_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d      = ONE;
                    head_bin_d   = enc_bin;
                    head_zero_d  = enc_zero;
                    head_multi_d = enc_multi;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_bin_d   = enc_bin;
                    head_zero_d  = enc_zero;
                    head_multi_d = enc_multi;
                end else if (push) begin
                    state_d      = FULL;
                    tail_bin_d   = enc_bin;
                    tail_zero_d  = enc_zero;
                    tail_multi_d = enc_multi;
                end else if (pop) begin
                    state_d      = EMPTY;
                end
            end
            FULL: begin
                // in_ready_o is low here, so only a pop can happen
                if (pop) begin
                    state_d      = ONE;
                    head_bin_d   = tail_bin_q;
                    head_zero_d  = tail_zero_q;
                    head_multi_d = tail_multi_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // Error status next-state; a clear coincident with a multi-hot accept keeps that event
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        if (err_clr_i) begin
            err_sticky_d = push & enc_multi;
            err_cnt_d    = (push & enc_multi) ? ERR_CNT_WIDTH'(1) : '0;
        end else if (push && enc_multi) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
            end
        end
    end

    // Buffer control and handshake registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Buffer entry storage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_bin_q   <= '0;
            head_zero_q  <= 1'b0;
            head_multi_q <= 1'b0;
            tail_bin_q   <= '0;
            tail_zero_q  <= 1'b0;
            tail_multi_q <= 1'b0;
        end else begin
            head_bin_q   <= head_bin_d;
            head_zero_q  <= head_zero_d;
            head_multi_q <= head_multi_d;
            tail_bin_q   <= tail_bin_d;
            tail_zero_q  <= tail_zero_d;
            tail_multi_q <= tail_multi_d;
        end
    end

    // Error status registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = out_valid_q;
    assign out_bin_o    = head_bin_q;
    assign out_zero_o   = head_zero_q;
    assign out_multi_o  = head_multi_q;
    assign err_sticky_o = err_sticky_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_onehot_to_bin_pipe_hyper.sv
// Bench for onehot_to_bin_pipe_hyper: three instances share one stimulus
// stream (W=16 LSB-priority, W=16 OR-encode with 2-bit counter, W=12
// LSB-priority). A queue-based model predicts every output each cycle.
module tb_onehot_to_bin_pipe_hyper;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_word;
    logic        out_ready;
    logic        err_clr;

    logic        rdy_x[3];
    logic        vld_x[3];
    logic [3:0]  bin_x[3];
    logic        zero_x[3];
    logic        multi_x[3];
    logic        st_x[3];
    logic [7:0]  cnt_x[3];
    logic [1:0]  cnt_b;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    // Model state
    logic [15:0] mq[$];
    int          mcnt[3];
    bit          mst[3];

    always #5 clk = ~clk;

    onehot_to_bin_pipe_hyper #(
        .ONEHOT_WIDTH(16), .PRIO_LSB(1'b1), .ERR_CNT_WIDTH(8)
    ) u_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_x[0]),
        .in_onehot_i(in_word), .out_valid_o(vld_x[0]), .out_ready_i(out_ready),
        .out_bin_o(bin_x[0]), .out_zero_o(zero_x[0]), .out_multi_o(multi_x[0]),
        .err_clr_i(err_clr), .err_sticky_o(st_x[0]), .err_cnt_o(cnt_x[0])
    );

    onehot_to_bin_pipe_hyper #(
        .ONEHOT_WIDTH(16), .PRIO_LSB(1'b0), .ERR_CNT_WIDTH(2)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_x[1]),
        .in_onehot_i(in_word), .out_valid_o(vld_x[1]), .out_ready_i(out_ready),
        .out_bin_o(bin_x[1]), .out_zero_o(zero_x[1]), .out_multi_o(multi_x[1]),
        .err_clr_i(err_clr), .err_sticky_o(st_x[1]), .err_cnt_o(cnt_b)
    );
    assign cnt_x[1] = {6'd0, cnt_b};

    onehot_to_bin_pipe_hyper #(
        .ONEHOT_WIDTH(12), .PRIO_LSB(1'b1), .ERR_CNT_WIDTH(8)
    ) u_c (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_x[2]),
        .in_onehot_i(in_word[11:0]), .out_valid_o(vld_x[2]), .out_ready_i(out_ready),
        .out_bin_o(bin_x[2]), .out_zero_o(zero_x[2]), .out_multi_o(multi_x[2]),
        .err_clr_i(err_clr), .err_sticky_o(st_x[2]), .err_cnt_o(cnt_x[2])
    );

    function automatic logic [15:0] mask_of(int k);
        return (k == 2) ? 16'h0FFF : 16'hFFFF;
    endfunction

    function automatic int cmax_of(int k);
        return (k == 1) ? 3 : 255;
    endfunction

    // Expected index: first set bit, or OR of every set bit position
    function automatic int exp_bin(logic [15:0] w, int k);
        int r;
        r = 0;
        if (k == 1) begin
            for (int i = 0; i < 16; i++) if (w[i]) r = r | i;
        end else begin
            for (int i = 15; i >= 0; i--) if (w[i]) r = i;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s[%0d]: got %0h expected %0h", name, k, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Model: FIFO of accepted raw words plus per-instance error state
    always @(posedge clk) begin
        bit push;
        bit pop;
        bit multi;
        logic [15:0] w;
        if (rst) begin
            mq.delete();
            for (int k = 0; k < 3; k++) begin
                mcnt[k] = 0;
                mst[k]  = 1'b0;
            end
        end else begin
            push = in_valid && (mq.size() < 2);
            pop  = (mq.size() > 0) && out_ready;
            for (int k = 0; k < 3; k++) begin
                w     = in_word & mask_of(k);
                multi = push && ($countones(w) >= 2);
                if (err_clr) begin
                    mcnt[k] = multi ? 1 : 0;
                    mst[k]  = multi;
                end else if (multi) begin
                    if (mcnt[k] < cmax_of(k)) mcnt[k] = mcnt[k] + 1;
                    mst[k] = 1'b1;
                end
            end
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(in_word);
        end
    end

    // Compare every instance against the model once per cycle
    always @(negedge clk) begin
        logic [15:0] w;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk("in_ready", k, 32'(rdy_x[k]), 32'(mq.size() < 2));
                chk("out_valid", k, 32'(vld_x[k]), 32'(mq.size() > 0));
                if (mq.size() > 0) begin
                    w = mq[0] & mask_of(k);
                    chk("out_bin", k, 32'(bin_x[k]), 32'(exp_bin(w, k)));
                    chk("out_zero", k, 32'(zero_x[k]), 32'(w == 16'h0));
                    chk("out_multi", k, 32'(multi_x[k]), 32'($countones(w) >= 2));
                end
                chk("err_cnt", k, 32'(cnt_x[k]), 32'(mcnt[k]));
                chk("err_sticky", k, 32'(st_x[k]), 32'(mst[k]));
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] w, input logic rdy,
                        input logic clr, input logic rs);
        in_valid  = v;
        in_word   = w;
        out_ready = rdy;
        err_clr   = clr;
        rst       = rs;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int sel;
        logic [15:0] w;
        in_valid = 1'b0; in_word = '0; out_ready = 1'b0; err_clr = 1'b0; rst = 1'b1;
        step(0, 16'h0, 0, 0, 1);
        step(0, 16'h0, 0, 0, 1);
        chk_en = 1'b1;

        // Reset state
        chk("rst_ready", 0, 32'(rdy_x[0]), 32'd1);
        chk("rst_valid", 0, 32'(vld_x[0]), 32'd0);
        chk("rst_bin", 0, 32'(bin_x[0]), 32'd0);
        chk("rst_zero", 0, 32'(zero_x[0]), 32'd0);
        chk("rst_multi", 0, 32'(multi_x[0]), 32'd0);
        chk("rst_cnt", 0, 32'(cnt_x[0]), 32'd0);
        chk("rst_sticky", 0, 32'(st_x[0]), 32'd0);
        step(0, 16'h0, 1, 0, 0);

        // Single-hot word, presented the cycle after acceptance
        step(1, 16'h0020, 1, 0, 0);
        chk("lit_valid_5", 0, 32'(vld_x[0]), 32'd1);
        chk("lit_bin_5", 0, 32'(bin_x[0]), 32'd5);
        chk("lit_zero_5", 0, 32'(zero_x[0]), 32'd0);
        chk("lit_multi_5", 0, 32'(multi_x[0]), 32'd0);

        // Zero word
        step(1, 16'h0000, 1, 0, 0);
        chk("lit_bin_z", 0, 32'(bin_x[0]), 32'd0);
        chk("lit_zero_z", 0, 32'(zero_x[0]), 32'd1);
        chk("lit_zero_zb", 1, 32'(zero_x[1]), 32'd1);

        // Multi-hot word in both encode modes
        step(1, 16'h0028, 1, 0, 0);
        chk("lit_bin_lsb", 0, 32'(bin_x[0]), 32'd3);
        chk("lit_bin_or", 1, 32'(bin_x[1]), 32'd7);
        chk("lit_multi", 0, 32'(multi_x[0]), 32'd1);
        chk("lit_cnt1", 0, 32'(cnt_x[0]), 32'd1);
        chk("lit_sticky1", 0, 32'(st_x[0]), 32'd1);
        step(0, 16'h0, 1, 0, 0);

        // Fill under backpressure; third word refused until space frees
        step(1, 16'h0001, 0, 0, 0);
        chk("lit_ready_one", 0, 32'(rdy_x[0]), 32'd1);
        step(1, 16'h0002, 0, 0, 0);
        chk("lit_ready_full", 0, 32'(rdy_x[0]), 32'd0);
        step(1, 16'h0004, 0, 0, 0);
        chk("lit_hold_bin", 0, 32'(bin_x[0]), 32'd0);
        chk("lit_hold_ready", 0, 32'(rdy_x[0]), 32'd0);
        step(1, 16'h0004, 1, 0, 0);
        chk("lit_order_bin1", 0, 32'(bin_x[0]), 32'd1);
        step(1, 16'h0004, 1, 0, 0);
        chk("lit_order_bin2", 0, 32'(bin_x[0]), 32'd2);
        step(0, 16'h0, 1, 0, 0);

        // Clear alone, then saturate the 2-bit counter
        step(0, 16'h0, 1, 1, 0);
        chk("lit_clr_cnt", 0, 32'(cnt_x[0]), 32'd0);
        chk("lit_clr_sticky", 0, 32'(st_x[0]), 32'd0);
        step(1, 16'h0003, 1, 0, 0);
        step(1, 16'h0006, 1, 0, 0);
        step(1, 16'h0C00, 1, 0, 0);
        step(1, 16'h8001, 1, 0, 0);
        step(1, 16'h00F0, 1, 0, 0);
        chk("lit_sat_b", 1, 32'(cnt_x[1]), 32'd3);
        chk("lit_cnt5_a", 0, 32'(cnt_x[0]), 32'd5);
        step(1, 16'h0011, 1, 1, 0);
        chk("lit_clr_multi_cnt", 1, 32'(cnt_x[1]), 32'd1);
        chk("lit_clr_multi_st", 1, 32'(st_x[1]), 32'd1);

        // Top bit of a 12-wide encoder
        step(1, 16'h0800, 1, 0, 0);
        chk("lit_bin11", 2, 32'(bin_x[2]), 32'd11);
        step(0, 16'h0, 1, 0, 0);

        // Reset with the buffer full, overriding clear and transfers
        step(1, 16'h0300, 0, 0, 0);
        step(1, 16'h0005, 0, 0, 0);
        chk("lit_full_ready", 0, 32'(rdy_x[0]), 32'd0);
        chk("lit_pre_rst_cnt", 0, 32'(cnt_x[0]), 32'd3);
        step(1, 16'h0003, 1, 1, 1);
        chk("lit_rst_valid", 0, 32'(vld_x[0]), 32'd0);
        chk("lit_rst_ready", 0, 32'(rdy_x[0]), 32'd1);
        chk("lit_rst_cnt", 0, 32'(cnt_x[0]), 32'd0);
        chk("lit_rst_bin", 2, 32'(bin_x[2]), 32'd0);
        step(0, 16'h0, 0, 0, 0);

        // Random soak against the model
        for (int n = 0; n < 10000; n++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) w = 16'h0;
            else if (sel == 3) w = 16'($urandom);
            else w = 16'h1 << $urandom_range(0, 15);
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 499) == 0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
